// File: rtl/render_scheduler_pkg.sv
// Shared types and sizes for the render scheduler: FSM states, sprite entry layout, field widths.
// Pure declarations, no logic.
package render_scheduler_pkg;

  localparam int          N_SPRITES   = 16;
  localparam int          IDX_W       = 4;
  localparam int          TILE_ADDR_W = 8;
  localparam int          POS_W       = 10;
  localparam int unsigned TIMEOUT_DEF = 65536;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [TILE_ADDR_W-1:0] tile;
    logic [POS_W-1:0]       top;
    logic [POS_W-1:0]       left;
  } sprite_t;

  function automatic logic idx_is_last(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(N_SPRITES - 1);
  endfunction

endpackage

// File: rtl/render_scheduler_if.sv
// Sprite-table write port plus the render_tile control bus (restart, parameters, finish).
// master = scheduler side, slave = CPU/table writer and tile engine side.
interface render_scheduler_if;
  import render_scheduler_pkg::*;

  logic                   tbl_wr;
  logic [IDX_W-1:0]       tbl_idx;
  logic                   tbl_valid;
  logic [TILE_ADDR_W-1:0] tbl_tile;
  logic [POS_W-1:0]       tbl_top;
  logic [POS_W-1:0]       tbl_left;

  logic                   tile_rstn;
  logic [TILE_ADDR_W-1:0] tile_addr;
  logic [POS_W-1:0]       tile_top;
  logic [POS_W-1:0]       tile_left;
  logic                   tile_finish;

  modport master (
    input  tbl_wr, tbl_idx, tbl_valid, tbl_tile, tbl_top, tbl_left,
    output tile_rstn, tile_addr, tile_top, tile_left,
    input  tile_finish
  );

  modport slave (
    output tbl_wr, tbl_idx, tbl_valid, tbl_tile, tbl_top, tbl_left,
    input  tile_rstn, tile_addr, tile_top, tile_left,
    output tile_finish
  );

endinterface

// File: rtl/render_scheduler_sprite_table.sv
// N-entry sprite register file: one write port (visible next cycle), async read by index.
// Only the valid bits are reset; entry data is don't-care until written.
module render_scheduler_sprite_table
  import render_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  sprite_t          wr_ent,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output sprite_t          rd_ent
);

  logic [N_SPRITES-1:0] valid_q, valid_d;
  sprite_t              ent_q [N_SPRITES];
  sprite_t              ent_d [N_SPRITES];

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    if (wr) begin
      valid_d[wr_idx] = wr_valid;
      ent_d[wr_idx]   = wr_ent;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_ent   = ent_q[rd_idx];

endmodule

// File: rtl/render_scheduler.sv
// Per-frame sequencer: walks the sprite table and runs render_tile once per valid entry.
// One SCAN cycle per entry, ARM+RUN per render; frame_start while busy is dropped and flagged.
module render_scheduler
  import render_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_start,
  input  logic              err_clr,
  render_scheduler_if.master bus,
  output logic              busy,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              frame_done,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int                WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                tile_rstn_q, tile_rstn_d;
  sprite_t             ent_q, ent_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;

  logic                advance;
  logic                timeout_set;
  logic                overrun_set;
  logic                rd_valid;
  sprite_t             rd_ent;
  sprite_t             wr_ent;

  assign wr_ent = '{tile: bus.tbl_tile, top: bus.tbl_top, left: bus.tbl_left};

  render_scheduler_sprite_table u_table (
    .clk      (clk),
    .rstn     (rstn),
    .wr       (bus.tbl_wr),
    .wr_idx   (bus.tbl_idx),
    .wr_valid (bus.tbl_valid),
    .wr_ent   (wr_ent),
    .rd_idx   (idx_q),
    .rd_valid (rd_valid),
    .rd_ent   (rd_ent)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wdog_d      = wdog_q;
    tile_rstn_d = tile_rstn_q;
    ent_d       = ent_q;
    advance     = 1'b0;
    timeout_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (rd_valid) begin
          ent_d   = rd_ent;
          state_d = ST_ARM;
        end else if (idx_is_last(idx_q)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ARM: begin
        wdog_d      = '0;
        tile_rstn_d = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // finish is checked first so a finish on the last watchdog cycle is not an error
        if (bus.tile_finish) begin
          advance = 1'b1;
        end else if (wdog_q == WDOG_LAST) begin
          advance     = 1'b1;
          timeout_set = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
        if (advance) begin
          tile_rstn_d = 1'b0;
          if (idx_is_last(idx_q)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        tile_rstn_d = 1'b0;
      end
    endcase
  end

  assign overrun_set = frame_start && (state_q != ST_IDLE);
  assign overrun_d   = overrun_set | (overrun_q & ~err_clr);
  assign timeout_d   = timeout_set | (timeout_q & ~err_clr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wdog_q      <= '0;
      tile_rstn_q <= 1'b0;
      ent_q       <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdog_q      <= wdog_d;
      tile_rstn_q <= tile_rstn_d;
      ent_q       <= ent_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.tile_rstn = tile_rstn_q;
  assign bus.tile_addr = ent_q.tile;
  assign bus.tile_top  = ent_q.top;
  assign bus.tile_left = ent_q.left;
  assign busy          = (state_q != ST_IDLE);
  assign cur_idx       = idx_q;
  assign frame_done    = (state_q == ST_DONE);
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler: directed frames plus randomized traffic, checked each cycle
// against a procedural frame-walk model.
module tb_render_scheduler;
  import render_scheduler_pkg::*;

  localparam int TO = 16;
  localparam int N  = N_SPRITES;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             frame_start = 1'b0;
  logic             err_clr = 1'b0;
  logic             busy, frame_done, overrun, timeout_err;
  logic [IDX_W-1:0] cur_idx;

  render_scheduler_if bus();

  render_scheduler #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .err_clr     (err_clr),
    .bus         (bus),
    .busy        (busy),
    .cur_idx     (cur_idx),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // ---------------- behavioural model: a frame is a timeline of edges ----------------
  logic                   m_busy = 0, m_tile_rstn = 0, m_frame_done = 0, m_overrun = 0, m_timeout = 0;
  logic [IDX_W-1:0]       m_cur_idx = '0;
  logic [TILE_ADDR_W-1:0] m_tile = '0;
  logic [POS_W-1:0]       m_top = '0, m_left = '0;
  logic                   mv [N];
  logic [TILE_ADDR_W-1:0] mt [N];
  logic [POS_W-1:0]       mtop [N], mleft [N];
  logic                   pv [N];
  logic [TILE_ADDR_W-1:0] pt [N];
  logic [POS_W-1:0]       ptop [N], pleft [N];
  logic                   fs_s = 0, fin_s = 0, ab = 0;

  task automatic model_edge();
    @(posedge clk);
    if (!rstn) begin
      ab = 1; fs_s = 0; fin_s = 0;
      m_busy = 0; m_tile_rstn = 0; m_frame_done = 0; m_overrun = 0; m_timeout = 0;
      m_cur_idx = '0; m_tile = '0; m_top = '0; m_left = '0;
      for (int i = 0; i < N; i++) begin mv[i] = 0; pv[i] = 0; end
      return;
    end
    fs_s  = frame_start;
    fin_s = bus.tile_finish;
    if (err_clr) begin m_overrun = 0; m_timeout = 0; end
    if (frame_start && m_busy) m_overrun = 1;
    pv = mv; pt = mt; ptop = mtop; pleft = mleft;
    if (bus.tbl_wr) begin
      mv[bus.tbl_idx]    = bus.tbl_valid;
      mt[bus.tbl_idx]    = bus.tbl_tile;
      mtop[bus.tbl_idx]  = bus.tbl_top;
      mleft[bus.tbl_idx] = bus.tbl_left;
    end
  endtask

  task automatic walk();
    ab = 0;
    for (int i = 0; i < N; i++) begin
      m_busy = 1;
      m_cur_idx = IDX_W'(i);
      model_edge(); if (ab) return;
      if (pv[i]) begin
        m_tile = pt[i]; m_top = ptop[i]; m_left = pleft[i];
        model_edge(); if (ab) return;
        m_tile_rstn = 1;
        for (int c = 1; c <= TO; c++) begin
          model_edge(); if (ab) return;
          if (fin_s) break;
          if (c == TO) m_timeout = 1;
        end
        m_tile_rstn = 0;
      end
    end
    m_frame_done = 1;
    model_edge(); if (ab) return;
    m_frame_done = 0;
    m_busy = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mt[i] = '0; mtop[i] = '0; mleft[i] = '0;
      pv[i] = 0; pt[i] = '0; ptop[i] = '0; pleft[i] = '0;
    end
    forever begin
      do model_edge(); while (!fs_s);
      walk();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      chk("busy",        busy,          m_busy);
      chk("tile_rstn",   bus.tile_rstn, m_tile_rstn);
      chk("frame_done",  frame_done,    m_frame_done);
      chk("overrun",     overrun,       m_overrun);
      chk("timeout_err", timeout_err,   m_timeout);
      chk("cur_idx",     cur_idx,       m_cur_idx);
      chk("tile_addr",   bus.tile_addr, m_tile);
      chk("tile_top",    bus.tile_top,  m_top);
      chk("tile_left",   bus.tile_left, m_left);
    end
  end

  // ---------------- observation of renders ----------------
  int          rises = 0, done_cnt = 0, hi = 0, last_hi = 0;
  logic        prev_rstn = 0;
  logic [31:0] cap_addr [64];
  logic [31:0] cap_top [64];
  logic [31:0] cap_left [64];

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.tile_rstn && !prev_rstn) begin
        cap_addr[rises % 64] = 32'(bus.tile_addr);
        cap_top[rises % 64]  = 32'(bus.tile_top);
        cap_left[rises % 64] = 32'(bus.tile_left);
        rises++;
      end
      if (bus.tile_rstn) hi++;
      else begin
        if (prev_rstn) last_hi = hi;
        hi = 0;
      end
      if (frame_done) done_cnt++;
      prev_rstn = bus.tile_rstn;
    end
  end

  // ---------------- tile engine stub ----------------
  int fix_lat = 5;
  bit stub_rand = 0;

  initial begin
    int scnt, cur_lat;
    scnt = 0; cur_lat = 5;
    bus.tile_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.tile_rstn) begin
        scnt = 0;
        bus.tile_finish = ($urandom_range(0, 3) == 0);
      end else begin
        scnt++;
        if (scnt == 1) cur_lat = stub_rand ? int'($urandom_range(1, TO + 6)) : fix_lat;
        bus.tile_finish = (scnt >= cur_lat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int idx, input bit v, input int tile, input int top, input int left);
    bus.tbl_wr    = 1'b1;
    bus.tbl_idx   = idx[IDX_W-1:0];
    bus.tbl_valid = v;
    bus.tbl_tile  = tile[TILE_ADDR_W-1:0];
    bus.tbl_top   = top[POS_W-1:0];
    bus.tbl_left  = left[POS_W-1:0];
    @(negedge clk);
    bus.tbl_wr = 1'b0;
  endtask

  task automatic run_frame(input string nm, output int n);
    frame_start = 1'b1;
    n = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      n++;
      if (frame_done) break;
    end
    if (!frame_done) bound_fail(nm);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic wait_rise(input string nm);
    for (int c = 0; c < 300; c++) begin
      if (bus.tile_rstn) return;
      @(negedge clk);
    end
    bound_fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 2000; c++) begin
      if (!busy) return;
      @(negedge clk);
    end
    bound_fail(nm);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, b, d;
    bus.tbl_wr = 0; bus.tbl_idx = '0; bus.tbl_valid = 0;
    bus.tbl_tile = '0; bus.tbl_top = '0; bus.tbl_left = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tile_rstn", bus.tile_rstn, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_tile_addr", bus.tile_addr, 0);
    rstn = 1'b1;
    @(negedge clk);

    // empty table: frame_done N+1 cycles after frame_start, no render
    b = rises;
    run_frame("empty_frame", n);
    chk("empty_len", n, N + 1);
    chk("empty_no_render", rises - b, 0);

    // entries 0 and 3, finish after 5 RUN cycles
    wr(0, 1, 1, 10, 20);
    wr(3, 1, 2, 100, 50);
    fix_lat = 5;
    b = rises; d = done_cnt;
    run_frame("two_frame", n);
    wait_idle("two_idle");
    chk("two_len", n, 29);
    chk("two_renders", rises - b, 2);
    chk("two_r0_addr", cap_addr[b % 64], 1);
    chk("two_r0_top", cap_top[b % 64], 10);
    chk("two_r0_left", cap_left[b % 64], 20);
    chk("two_r1_addr", cap_addr[(b + 1) % 64], 2);
    chk("two_r1_top", cap_top[(b + 1) % 64], 100);
    chk("two_r1_left", cap_left[(b + 1) % 64], 50);
    chk("two_done_once", done_cnt - d, 1);

    // second frame_start during RUN
    fix_lat = 8;
    b = rises; d = done_cnt;
    pulse_start();
    wait_rise("ovr_rise");
    @(negedge clk); @(negedge clk);
    pulse_start();
    chk("ovr_set", overrun, 1);
    wait_idle("ovr_idle");
    chk("ovr_renders", rises - b, 2);
    chk("ovr_done_once", done_cnt - d, 1);
    pulse_clr();
    chk("ovr_clr", overrun, 0);

    // finish never comes: watchdog ends each render
    fix_lat = 1000;
    b = rises;
    pulse_start();
    wait_idle("to_idle");
    chk("to_run_len", last_hi, TO);
    chk("to_flag", timeout_err, 1);
    chk("to_renders", rises - b, 2);
    pulse_clr();
    chk("to_clr", timeout_err, 0);
    fix_lat = TO;
    pulse_start();
    wait_idle("to_edge_idle");
    chk("to_edge_len", last_hi, TO);
    chk("to_edge_noflag", timeout_err, 0);

    // table writes during a render
    wr(0, 0, 0, 0, 0);
    wr(3, 0, 0, 0, 0);
    wr(2, 1, 4, 30, 40);
    wr(5, 1, 3, 60, 70);
    fix_lat = 10;
    b = rises;
    pulse_start();
    wait_rise("wr_rise");
    wr(5, 1, 7, 60, 70);
    wr(2, 1, 9, 1, 1);
    chk("wr_hold_addr", bus.tile_addr, 4);
    chk("wr_hold_top", bus.tile_top, 30);
    wait_idle("wr_idle");
    chk("wr_renders", rises - b, 2);
    chk("wr_e5_addr", cap_addr[(b + 1) % 64], 7);

    // reset in the middle of a render
    fix_lat = 1000;
    pulse_start();
    wait_rise("rst_rise");
    @(negedge clk); @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_tile_rstn", bus.tile_rstn, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    b = rises;
    run_frame("rst_after_frame", n);
    chk("rst_after_len", n, N + 1);
    chk("rst_after_renders", rises - b, 0);

    // randomized traffic
    stub_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      bus.tbl_wr    = ($urandom_range(0, 9) < 2);
      bus.tbl_idx   = IDX_W'($urandom);
      bus.tbl_valid = ($urandom_range(0, 2) != 0);
      bus.tbl_tile  = TILE_ADDR_W'($urandom);
      bus.tbl_top   = POS_W'($urandom);
      bus.tbl_left  = POS_W'($urandom);
      frame_start   = ($urandom_range(0, 59) == 0);
      err_clr       = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        bus.tbl_wr = 0; frame_start = 0; err_clr = 0;
        rstn = 1'b0;
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
      end
      @(negedge clk);
    end
    bus.tbl_wr = 0; frame_start = 0; err_clr = 0;
    wait_idle("final_idle");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
